// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// Posted-write FIFO placed directly in front of the data memory write port.
// Word stores from the CPU memory stage are queued and written to data memory
// one per cycle, in the order they were accepted. Loads see the data of the
// youngest pending store to the same word, so they never read stale memory.
//
// Ports
//   clk, reset        clock; synchronous active-high reset (clears all state)
//   st_valid/ready    store handshake; st_ready drops when count == DEPTH
//   st_pc/addr/wd     store PC, byte address, word data
//   ld_addr           load address used for the forwarding lookup
//   ld_hit/ld_data    forwarding result (ld_data is 0 on a miss)
//   dm_stall          data memory cannot take a write this cycle
//   dm_we/pc/addr/wd  head entry presented to data memory (zeros when empty)
//   count, empty      occupancy, so the CPU can stall on full and drain on halt
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [31:0]        st_pc,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_wd,
  input  logic [31:0]        ld_addr,
  output logic               ld_hit,
  output logic [31:0]        ld_data,
  input  logic               dm_stall,
  output logic               dm_we,
  output logic [31:0]        dm_pc,
  output logic [31:0]        dm_addr,
  output logic [31:0]        dm_wd,
  output logic [PTR_W:0]     count,
  output logic               empty
);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_r;
  logic             accept;
  logic             drain;

  // Byte-lane bits of the load address play no part in word matching.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign count    = count_r;
  assign empty    = (count_r == '0);
  // Full means not ready even if the head drains this same cycle.
  assign st_ready = (count_r != (PTR_W+1)'(DEPTH));
  assign accept   = st_valid && st_ready && !reset;
  // Reset has priority: nothing may be written to memory in the reset cycle.
  assign dm_we    = !reset && !empty && !dm_stall;
  assign drain    = dm_we;

  assign dm_pc   = empty ? 32'h0 : pc_mem[head];
  assign dm_addr = empty ? 32'h0 : addr_mem[head];
  assign dm_wd   = empty ? 32'h0 : data_mem[head];

  // Control state: valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      // head == tail only when empty or full, so accept and drain never
      // touch the same slot in one cycle.
      if (accept) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({accept, drain})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload; qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[tail]   <= st_pc;
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_wd;
    end
  end

  // Forwarding lookup. Slots are visited oldest to youngest (tail-DEPTH up to
  // tail-1) so the last match written is the youngest one. The entry being
  // drained this cycle is still valid and therefore still eligible.
  always_comb begin
    logic [PTR_W-1:0] idx;
    ld_hit  = 1'b0;
    ld_data = 32'h0;
    idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail - PTR_W'(1) - PTR_W'(i);
      if (valid[idx] && (addr_mem[idx][31:2] == ld_addr[31:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios followed by
// random traffic, checked by a queue-based reference model and a monitor.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [31:0]      st_pc = '0;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_wd = '0;
  logic [31:0]      ld_addr = '0;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             dm_stall = 1'b0;
  logic             dm_we;
  logic [31:0]      dm_pc;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wd;
  logic [PTR_W:0]   count;
  logic             empty;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_pc(st_pc), .st_addr(st_addr), .st_wd(st_wd),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_stall(dm_stall), .dm_we(dm_we),
    .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
  } ent_t;

  ent_t exp_q[$];       // pending stores, oldest first
  int   checks   = 0;
  int   failures = 0;
  bit   armed    = 1'b0;
  bit   done     = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!done) begin
      if (armed) begin
        logic        m_full, m_we, m_hit;
        logic [31:0] m_ld;
        m_full = (exp_q.size() == DEPTH);
        m_we   = !reset && (exp_q.size() != 0) && !dm_stall;
        m_hit  = 1'b0;
        m_ld   = 32'h0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (!m_hit && exp_q[i].addr[31:2] == ld_addr[31:2]) begin
            m_hit = 1'b1;
            m_ld  = exp_q[i].wd;
          end
        end
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("empty", 64'(empty), 64'(exp_q.size() == 0));
        chk("st_ready", 64'(st_ready), 64'(!m_full));
        chk("dm_we", 64'(dm_we), 64'(m_we));
        chk("ld_hit", 64'(ld_hit), 64'(m_hit));
        chk("ld_data", 64'(ld_data), 64'(m_ld));
        if (exp_q.size() != 0) begin
          chk("dm_addr", 64'(dm_addr), 64'(exp_q[0].addr));
          chk("dm_wd", 64'(dm_wd), 64'(exp_q[0].wd));
          chk("dm_pc", 64'(dm_pc), 64'(exp_q[0].pc));
        end else begin
          chk("dm_addr_idle", 64'(dm_addr), 64'h0);
          chk("dm_wd_idle", 64'(dm_wd), 64'h0);
          chk("dm_pc_idle", 64'(dm_pc), 64'h0);
        end
        // State update at the coming rising edge.
        if (reset) begin
          exp_q.delete();
        end else begin
          if (m_we) void'(exp_q.pop_front());
          if (st_valid && !m_full) exp_q.push_back('{st_pc, st_addr, st_wd});
        end
      end else if (reset) begin
        armed = 1'b1;
        exp_q.delete();
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] la, input logic stall);
    st_valid = v;
    st_pc    = pc;
    st_addr  = a;
    st_wd    = wd;
    ld_addr  = la;
    dm_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic stall, input logic [31:0] la);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 32'h0, la, stall);
  endtask

  initial begin
    reset = 1'b1;
    idle(2, 1'b0, 32'h0);
    reset = 1'b0;
    idle(1, 1'b0, 32'h0);

    // Single store then idle.
    cyc(1'b1, 32'h3000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    idle(3, 1'b0, 32'h10);

    // Fill under stall; the fifth store is refused.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h100 + 32'(i * 4), 32'(i * 4), 32'hA000 + 32'(i), 32'h8, 1'b1);
    idle(2, 1'b1, 32'hC);
    idle(6, 1'b0, 32'h0);

    // Youngest-match forwarding.
    cyc(1'b1, 32'h200, 32'h20, 32'h11111111, 32'h0, 1'b1);
    cyc(1'b1, 32'h204, 32'h20, 32'h22222222, 32'h0, 1'b1);
    idle(1, 1'b1, 32'h22);
    idle(1, 1'b1, 32'h24);
    idle(4, 1'b0, 32'h20);

    // Simultaneous enqueue and drain, pointers wrap several times.
    for (int i = 0; i < 11; i++)
      cyc(1'b1, 32'h400 + 32'(i * 4), 32'h1000 + 32'(i * 4), 32'hB000 + 32'(i), 32'h1000, 1'b0);
    idle(3, 1'b0, 32'h0);

    // Reset mid-operation discards pending stores.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h500, 32'h2000 + 32'(i * 4), 32'hC000 + 32'(i), 32'h2000, 1'b1);
    reset = 1'b1;
    idle(1, 1'b0, 32'h2000);
    reset = 1'b0;
    idle(3, 1'b0, 32'h2004);

    // Forward during the drain cycle.
    cyc(1'b1, 32'h600, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0);
    idle(2, 1'b0, 32'h40);

    // Random traffic over a small address set so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, la;
      a  = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      la = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      cyc(1'($urandom_range(0, 99) < 60), $urandom, a, $urandom, la,
          1'($urandom_range(0, 99) < 30));
    end

    idle(DEPTH + 3, 1'b0, 32'h0);
    chk("final_queue_drained", 64'(exp_q.size()), 64'h0);
    chk("final_empty", 64'(empty), 64'h1);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write FIFO directly upstream of the data memory.
- Accepts word stores from the CPU memory stage and retires them to the data memory write port one per cycle, in program order.
- Forwards buffered data to loads whose word address matches a pending store, so loads never read stale memory.
- Reports occupancy so the CPU can stall on full and drain before a halt.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- st_valid  in  1  CPU presents a store this cycle.
- st_ready  out  1  buffer can accept a store this cycle.
- st_pc  in  32  PC of the storing instruction, carried through for the write log.
- st_addr  in  32  store byte address; bits [1:0] are carried through but ignored for matching.
- st_wd  in  32  store data, full word.
- ld_addr  in  32  current load address, used for forwarding lookup.
- ld_hit  out  1  a buffered store matches ld_addr[31:2].
- ld_data  out  32  data of the youngest matching entry; 0 when ld_hit=0.
- dm_stall  in  1  data memory cannot accept a write this cycle.
- dm_we  out  1  write strobe to data memory.
- dm_pc  out  32  PC of the head entry.
- dm_addr  out  32  address of the head entry.
- dm_wd  out  32  data of the head entry.
- count  out  PTR_W+1  number of valid entries.
- empty  out  1  count == 0.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {pc, addr, data, valid}.
  - head pointer (oldest entry), tail pointer (next free slot), count register.
  - Pointers wrap modulo DEPTH.
- Reset:
  - valid bits, head, tail and count all go to 0.
  - Resulting outputs: st_ready=1, empty=1, dm_we=0, ld_hit=0, ld_data=0, dm_pc/dm_addr/dm_wd=0.
  - Reset mid-operation discards every pending store; no dm_we is asserted in the reset cycle.
- Enqueue:
  - st_ready = (count != DEPTH), combinational.
  - An accept occurs when st_valid && st_ready.
  - On accept, write entry[tail] with valid=1 and advance tail.
  - st_valid while full is ignored; no state changes and the CPU must hold the store.
  - st_ready does not account for a same-cycle drain; full means not ready, even when a drain occurs that cycle.
- Drain:
  - dm_we = !empty && !dm_stall, combinational.
  - dm_pc, dm_addr and dm_wd show entry[head] whenever not empty, and 0 when empty.
  - On the edge where dm_we=1: clear entry[head].valid and advance head. Data memory samples the same values at that same edge.
  - Latency: a store accepted at edge N reaches the DM port in cycle N+1 (empty buffer, no stall) and is written at edge N+1.
- Count update per edge:
  - +1 on accept only.
  - −1 on drain only.
  - Unchanged when both occur or neither occurs.
  - Simultaneous accept and drain when count==1: head and tail both advance and the new entry becomes head.
- Forwarding (combinational):
  - Compare ld_addr[31:2] against addr[31:2] of every valid entry.
  - When several entries match, the youngest wins: the matching entry closest to tail−1, scanning backwards with wrap.
  - The entry being drained in the current cycle remains eligible, since DM still returns old data this cycle.
  - A store being accepted in the same cycle is not visible to the lookup; the CPU pipeline handles that hazard.
- Ordering: stores retire strictly in acceptance order, including repeated stores to the same address. No coalescing.
- dm_stall held high: the head is frozen, the buffer fills, and st_ready drops at count==DEPTH.

Test Plan:
- Single store, then idle: reset, then st_valid with pc=0x3000, addr=0x10, wd=0xDEADBEEF for one cycle -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF, dm_pc=0x3000; the following cycle empty=1 and dm_we=0.
- Fill under stall: dm_stall=1 and 5 stores to 0x0, 0x4, 0x8, 0xC, 0x10 -> count reaches 4, st_ready=0, fifth store not accepted. Release dm_stall -> four writes in order 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Youngest-match forwarding: under stall, store 0x11111111 to 0x20, then 0x22222222 to 0x20, then ld_addr=0x22 -> ld_hit=1, ld_data=0x22222222. With ld_addr=0x24 -> ld_hit=0, ld_data=0.
- Simultaneous enqueue and drain: one entry pending, dm_stall=0, new store accepted in the same cycle -> count stays 1, next dm_addr is the new store's address. Run 10 cycles of back-to-back single stores so pointers wrap past DEPTH with no lost or duplicated write.
- Reset mid-operation: 3 entries pending under stall, assert reset for one cycle -> count=0, empty=1, dm_we=0 in and after the reset cycle; none of the discarded addresses is ever written.
- Forward during drain cycle: one entry at 0x40 with data 0xA5A5A5A5, dm_stall=0, ld_addr=0x40 in the drain cycle -> ld_hit=1, ld_data=0xA5A5A5A5, dm_we=1. Next cycle ld_hit=0.
